// File: rtl/bonus_effect_ctrl_if.sv
// Signal bundle between the falling-bonus array / game core and the bonus effect controller.
// The master side drives frame, slot and life-loss inputs; the slave side returns layer and effect state.
interface bonus_effect_ctrl_if;
    logic             startOfFrame;
    logic [15:0]      bonusDrawReq;
    logic [15:0][7:0] bonusRGB;
    logic [15:0][2:0] outBonusCode;
    logic             lifeLost;

    logic             bonusLayerDrawReq;
    logic [7:0]       bonusLayerRGB;
    logic             widePaddle;
    logic             slowBall;
    logic             doubleScore;
    logic [3:0]       lives;
    logic             gameOver;

    modport master (
        output startOfFrame, bonusDrawReq, bonusRGB, outBonusCode, lifeLost,
        input  bonusLayerDrawReq, bonusLayerRGB, widePaddle, slowBall, doubleScore, lives, gameOver
    );

    modport slave (
        input  startOfFrame, bonusDrawReq, bonusRGB, outBonusCode, lifeLost,
        output bonusLayerDrawReq, bonusLayerRGB, widePaddle, slowBall, doubleScore, lives, gameOver
    );
endinterface

// File: rtl/bonus_effect_ctrl.sv
// Merges the 16 bonus slots into one video layer and turns caught bonuses into timed
// game effects and extra lives; owns the lives counter.
module bonus_effect_ctrl #(
    parameter int unsigned DURATION_FRAMES = 600,
    parameter int unsigned TIMER_W         = 10,
    parameter int unsigned INIT_LIVES      = 3,
    parameter int unsigned MAX_LIVES       = 9
) (
    input logic                clk,
    input logic                reset,
    bonus_effect_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] DUR    = TIMER_W'(DURATION_FRAMES);
    localparam logic [3:0]         INIT_L = 4'(INIT_LIVES);
    localparam logic [3:0]         MAX_L  = 4'(MAX_LIVES);

    localparam int unsigned EFF_WIDE   = 0;
    localparam int unsigned EFF_SLOW   = 1;
    localparam int unsigned EFF_DOUBLE = 2;

    logic                      draw_d, draw_q;
    logic [7:0]                rgb_d, rgb_q;
    logic [15:0][2:0]          code_prev_q;
    logic [15:0]               catch_ev;
    logic [15:0]               pending_d, pending_q;
    logic [15:0][2:0]          pend_code_d, pend_code_q;
    logic                      svc_valid;
    logic [3:0]                svc_idx;
    logic [2:0]                svc_code;
    logic [2:0]                load;
    logic                      extra_life;
    logic [2:0][TIMER_W-1:0]   timer_d, timer_q;
    logic [2:0]                eff_q;
    logic [3:0]                lives_d, lives_q;
    logic                      go_q;

    // Draw merge: lowest-index requesting slot wins the colour.
    always_comb begin
        draw_d = |bus.bonusDrawReq;
        rgb_d  = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (bus.bonusDrawReq[i]) rgb_d = bus.bonusRGB[i];
        end
    end

    // A catch is only the 0 -> non-zero transition of a slot code.
    always_comb begin
        catch_ev = '0;
        for (int i = 0; i < 16; i++) begin
            catch_ev[i] = (bus.outBonusCode[i] != 3'd0) && (code_prev_q[i] == 3'd0);
        end
    end

    always_comb begin
        svc_valid = 1'b0;
        svc_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                svc_valid = 1'b1;
                svc_idx   = 4'(i);
            end
        end
    end

    assign svc_code = pend_code_q[svc_idx];

    always_comb begin
        pending_d   = pending_q;
        pend_code_d = pend_code_q;
        if (svc_valid) pending_d[svc_idx] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (catch_ev[i]) begin
                pending_d[i]   = 1'b1;
                pend_code_d[i] = bus.outBonusCode[i];
            end
        end
    end

    assign load[EFF_WIDE]   = svc_valid && (svc_code == 3'd1);
    assign load[EFF_SLOW]   = svc_valid && (svc_code == 3'd2);
    assign load[EFF_DOUBLE] = svc_valid && (svc_code == 3'd4);
    assign extra_life       = svc_valid && (svc_code == 3'd3);

    // Reload has priority over the frame decrement; re-catches restart rather than stack.
    always_comb begin
        timer_d = timer_q;
        for (int e = 0; e < 3; e++) begin
            if (load[e]) begin
                timer_d[e] = DUR;
            end else if (bus.startOfFrame && (timer_q[e] != '0)) begin
                timer_d[e] = timer_q[e] - 1'b1;
            end
        end
    end

    always_comb begin
        lives_d = lives_q;
        if (extra_life && bus.lifeLost) begin
            if (lives_q == 4'd0) lives_d = 4'd1;
        end else if (extra_life) begin
            if (lives_q < MAX_L) lives_d = lives_q + 4'd1;
        end else if (bus.lifeLost && (lives_q != 4'd0)) begin
            lives_d = lives_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draw_q      <= 1'b0;
            rgb_q       <= 8'h00;
            code_prev_q <= '0;
            pending_q   <= '0;
            pend_code_q <= '0;
            timer_q     <= '0;
            eff_q       <= '0;
            lives_q     <= INIT_L;
            go_q        <= 1'b0;
        end else begin
            draw_q      <= draw_d;
            rgb_q       <= rgb_d;
            code_prev_q <= bus.outBonusCode;
            pending_q   <= pending_d;
            pend_code_q <= pend_code_d;
            timer_q     <= timer_d;
            for (int e = 0; e < 3; e++) eff_q[e] <= (timer_q[e] != '0);
            lives_q     <= lives_d;
            go_q        <= (lives_q == 4'd0);
        end
    end

    assign bus.bonusLayerDrawReq = draw_q;
    assign bus.bonusLayerRGB     = rgb_q;
    assign bus.widePaddle        = eff_q[EFF_WIDE];
    assign bus.slowBall          = eff_q[EFF_SLOW];
    assign bus.doubleScore       = eff_q[EFF_DOUBLE];
    assign bus.lives             = lives_q;
    assign bus.gameOver          = go_q;

endmodule

// File: tb/tb_bonus_effect_ctrl.sv
// Scoreboard bench for bonus_effect_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares; directed sequences follow the test plan, then random traffic.
module tb_bonus_effect_ctrl;

    localparam int DUR = 600;
    localparam int MAXL = 9;
    localparam int INITL = 3;

    typedef struct {
        bit draw;
        int rgb;
        bit wp;
        bit sb;
        bit ds;
        int lives;
        bit go;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bonus_effect_ctrl_if bus ();

    bonus_effect_ctrl #(
        .DURATION_FRAMES(DUR),
        .TIMER_W        (10),
        .INIT_LIVES     (INITL),
        .MAX_LIVES      (MAXL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Behavioural model state
    int m_prev[16];
    int m_pcode[16];
    bit m_pend[16];
    int m_timer[3];
    int m_lives;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int eff_code(int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_prev[i] = 0; m_pcode[i] = 0; m_pend[i] = 1'b0;
        end
        for (int k = 0; k < 3; k++) m_timer[k] = 0;
        m_lives = INITL;
    endtask

    // Advance the model over one clock edge using the inputs currently driven.
    task automatic model_step(output exp_t e);
        int svc, sc, c, nl;
        bit lost;
        svc = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i]) begin svc = i; break; end
        end
        sc = (svc >= 0) ? m_pcode[svc] : 0;
        lost = bus.lifeLost;

        e.wp = (m_timer[0] != 0);
        e.sb = (m_timer[1] != 0);
        e.ds = (m_timer[2] != 0);
        e.go = (m_lives == 0);

        if (svc >= 0) m_pend[svc] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = int'(bus.outBonusCode[i]);
            if (c != 0 && m_prev[i] == 0) begin
                m_pend[i]  = 1'b1;
                m_pcode[i] = c;
            end
            m_prev[i] = c;
        end

        for (int k = 0; k < 3; k++) begin
            if (sc == eff_code(k)) m_timer[k] = DUR;
            else if (bus.startOfFrame && m_timer[k] > 0) m_timer[k] = m_timer[k] - 1;
        end

        if (sc == 3 && lost) nl = (m_lives == 0) ? 1 : m_lives;
        else if (sc == 3) nl = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
        else if (lost) nl = (m_lives > 0) ? m_lives - 1 : 0;
        else nl = m_lives;
        m_lives = nl;
        e.lives = nl;

        e.draw = (bus.bonusDrawReq != 16'h0);
        e.rgb  = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.bonusDrawReq[i]) begin e.rgb = int'(bus.bonusRGB[i]); break; end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_step(e);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("drawReq", 32'(bus.bonusLayerDrawReq), 32'(e.draw));
            chk("rgb", 32'(bus.bonusLayerRGB), 32'(e.rgb));
            chk("widePaddle", 32'(bus.widePaddle), 32'(e.wp));
            chk("slowBall", 32'(bus.slowBall), 32'(e.sb));
            chk("doubleScore", 32'(bus.doubleScore), 32'(e.ds));
            chk("lives", 32'(bus.lives), 32'(e.lives));
            chk("gameOver", 32'(bus.gameOver), 32'(e.go));
        end
    end

    task automatic check_reset_values(string tag);
        chk({tag, "_drawReq"}, 32'(bus.bonusLayerDrawReq), 32'd0);
        chk({tag, "_rgb"}, 32'(bus.bonusLayerRGB), 32'd0);
        chk({tag, "_widePaddle"}, 32'(bus.widePaddle), 32'd0);
        chk({tag, "_slowBall"}, 32'(bus.slowBall), 32'd0);
        chk({tag, "_doubleScore"}, 32'(bus.doubleScore), 32'd0);
        chk({tag, "_lives"}, 32'(bus.lives), 32'(INITL));
        chk({tag, "_gameOver"}, 32'(bus.gameOver), 32'd0);
    endtask

    task automatic catch_code(int slot, int code);
        bus.outBonusCode[slot] = 3'(code);
        cycle();
        bus.outBonusCode[slot] = 3'd0;
        cycle();
    endtask

    task automatic pulse_lost();
        bus.lifeLost = 1'b1;
        cycle();
        bus.lifeLost = 1'b0;
    endtask

    initial begin
        int k;
        logic [2:0] c;
        reset             = 1'b1;
        bus.startOfFrame  = 1'b0;
        bus.bonusDrawReq  = '0;
        bus.outBonusCode  = '0;
        bus.lifeLost      = 1'b0;
        for (int i = 0; i < 16; i++) bus.bonusRGB[i] = 8'($urandom);
        model_reset();
        #2;
        check_reset_values("por");
        #10 reset = 1'b0;

        // Draw merge
        bus.bonusDrawReq = 16'h0024;
        bus.bonusRGB[5]  = 8'hE0;
        bus.bonusRGB[2]  = 8'h1C;
        cycle();
        chk("merge_req", 32'(bus.bonusLayerDrawReq), 32'd1);
        chk("merge_rgb", 32'(bus.bonusLayerRGB), 32'h1C);
        bus.bonusDrawReq = 16'h0000;
        cycle();
        chk("idle_req", 32'(bus.bonusLayerDrawReq), 32'd0);
        chk("idle_rgb", 32'(bus.bonusLayerRGB), 32'h00);

        // Held code counts once; widePaddle lasts exactly the duration
        bus.outBonusCode[3] = 3'd1;
        cycle(); chk("wp_e0", 32'(bus.widePaddle), 32'd0);
        cycle(); chk("wp_e1", 32'(bus.widePaddle), 32'd0);
        cycle(); chk("wp_e2", 32'(bus.widePaddle), 32'd1);
        cycle();
        bus.outBonusCode[3] = 3'd0;
        cycle();
        bus.startOfFrame = 1'b1;
        for (int i = 0; i < DUR; i++) cycle();
        bus.startOfFrame = 1'b0;
        chk("wp_after600_lag", 32'(bus.widePaddle), 32'd1);
        cycle();
        chk("wp_expired", 32'(bus.widePaddle), 32'd0);

        // Simultaneous catches drain lowest slot first
        bus.outBonusCode[9] = 3'd1;
        bus.outBonusCode[0] = 3'd2;
        bus.outBonusCode[7] = 3'd4;
        cycle();
        bus.outBonusCode = '0;
        cycle();
        cycle();
        chk("order_sb", 32'(bus.slowBall), 32'd1);
        chk("order_ds_early", 32'(bus.doubleScore), 32'd0);
        cycle();
        chk("order_ds", 32'(bus.doubleScore), 32'd1);
        chk("order_wp_early", 32'(bus.widePaddle), 32'd0);
        cycle();
        chk("order_wp", 32'(bus.widePaddle), 32'd1);

        // Reload coincident with a frame tick restores the full duration
        bus.startOfFrame = 1'b1;
        k = 0;
        while (m_timer[0] > 5 && k < 700) begin cycle(); k++; end
        bus.startOfFrame = 1'b0;
        bus.outBonusCode[1] = 3'd1;
        cycle();
        bus.outBonusCode[1] = 3'd0;
        bus.startOfFrame = 1'b1;
        cycle();
        k = 0;
        while (bus.widePaddle && k < 700) begin cycle(); k++; end
        bus.startOfFrame = 1'b0;
        chk("reload_len", 32'(k), 32'd601);

        // Lives saturation, game over and recovery
        for (int i = 0; i < 7; i++) catch_code(4, 3);
        cycle();
        chk("lives_sat", 32'(bus.lives), 32'(MAXL));
        for (int i = 0; i < MAXL - 1; i++) pulse_lost();
        chk("lives_one", 32'(bus.lives), 32'd1);
        pulse_lost();
        cycle();
        chk("lives_zero", 32'(bus.lives), 32'd0);
        chk("gameover_set", 32'(bus.gameOver), 32'd1);
        pulse_lost();
        chk("lives_floor", 32'(bus.lives), 32'd0);
        catch_code(12, 3);
        chk("lives_revive", 32'(bus.lives), 32'd1);
        cycle();
        chk("gameover_clr", 32'(bus.gameOver), 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bus.bonusDrawReq = 16'($urandom & $urandom & $urandom);
            for (int i = 0; i < 16; i++) begin
                bus.bonusRGB[i] = 8'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    c = bus.outBonusCode[i];
                    if (c == 3'd0) c = 3'($urandom_range(1, 7));
                    else if ($urandom_range(0, 1) == 0) c = 3'd0;
                    else c = 3'($urandom_range(1, 7));
                    bus.outBonusCode[i] = c;
                end
            end
            bus.startOfFrame = ($urandom_range(0, 1) == 0);
            bus.lifeLost     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        bus.outBonusCode = '0;
        bus.startOfFrame = 1'b0;
        bus.lifeLost     = 1'b0;
        bus.bonusDrawReq = '0;
        for (int i = 0; i < 4; i++) cycle();

        // Reset in the middle of servicing
        catch_code(6, 2);
        cycle();
        chk("pre_reset_sb", 32'(bus.slowBall), 32'd1);
        bus.outBonusCode[2]  = 3'd1;
        bus.outBonusCode[8]  = 3'd3;
        bus.outBonusCode[11] = 3'd4;
        bus.bonusDrawReq     = 16'h0100;
        cycle();
        reset = 1'b1;
        #2;
        check_reset_values("midrst");
        exp_q.delete();
        model_reset();
        bus.outBonusCode = '0;
        bus.bonusDrawReq = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("post_rst_wp", 32'(bus.widePaddle), 32'd0);
        chk("post_rst_sb", 32'(bus.slowBall), 32'd0);
        chk("post_rst_ds", 32'(bus.doubleScore), 32'd0);
        chk("post_rst_lives", 32'(bus.lives), 32'(INITL));

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
